// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch FSM encoding, PC step and branch opcode constants,
// and the offset alignment helper.
package rv_core_pkg;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT_RSP,
      S_HOLD,
      S_WAIT_NEXT,
      S_ERR
   } fetch_state_e;

   localparam logic [31:0] PC_INC     = 32'd4;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   // Instructions are word aligned, so any offset with low bits set is unusable.
   function automatic logic offset_misaligned(input logic [31:0] offset);
      return offset[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: next-PC offset input, imem request/response, decode handshake, error flag.
interface pc_fetch_unit_if;

   logic [31:0] pc_offset;
   logic        offset_valid;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_err;

   modport master (
      input  pc_offset, offset_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      output imem_req_valid, imem_addr, instr, instr_pc, instr_valid, fetch_err
   );

   modport slave (
      output pc_offset, offset_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid, fetch_err
   );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles while enabled; expired flags the LIMIT-th enabled cycle since the last clear.
module fetch_timeout_ctr #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Non-speculative instruction fetch: owns the PC, issues one imem request at a time and
// hands a registered instruction to decode before applying the next-PC offset.
module pc_fetch_unit
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic             clk,
   input logic             rst,
   pc_fetch_unit_if.master bus
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  instr_q;
   logic [31:0]  instr_pc_q;
   logic         instr_valid_q;
   logic         req_valid_q;
   logic         fetch_err_q;

   logic ctr_clear;
   logic ctr_enable;
   logic timeout_hit;
   logic bad_offset;

   assign ctr_clear  = (state_q == S_REQ);
   assign ctr_enable = (state_q == S_WAIT_RSP);
   assign bad_offset = offset_misaligned(bus.pc_offset);

   fetch_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (ctr_clear),
      .enable  (ctr_enable),
      .expired (timeout_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         req_valid_q   <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_REQ: begin
               // Request rises one cycle after reset release, then holds until accepted.
               req_valid_q <= 1'b1;
               if (req_valid_q && bus.imem_req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               // A response on the limit cycle still wins over the timeout.
               if (bus.imem_rsp_valid) begin
                  instr_q       <= bus.imem_rsp_data;
                  instr_pc_q    <= pc_q;
                  instr_valid_q <= 1'b1;
                  state_q       <= S_HOLD;
               end else if (timeout_hit) begin
                  fetch_err_q <= 1'b1;
                  state_q     <= S_ERR;
               end
            end
            S_HOLD, S_WAIT_NEXT: begin
               if (state_q == S_WAIT_NEXT || bus.instr_ready) begin
                  instr_valid_q <= 1'b0;
                  if (!bus.offset_valid) begin
                     state_q <= S_WAIT_NEXT;
                  end else if (bad_offset) begin
                     fetch_err_q <= 1'b1;
                     state_q     <= S_ERR;
                  end else begin
                     pc_q        <= pc_q + bus.pc_offset;
                     req_valid_q <= 1'b1;
                     state_q     <= S_REQ;
                  end
               end
            end
            S_ERR: begin
               req_valid_q   <= 1'b0;
               instr_valid_q <= 1'b0;
               fetch_err_q   <= 1'b1;
            end
            default: begin
               req_valid_q   <= 1'b0;
               instr_valid_q <= 1'b0;
               fetch_err_q   <= 1'b1;
               state_q       <= S_ERR;
            end
         endcase
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_addr      = pc_q;
   assign bus.instr          = instr_q;
   assign bus.instr_pc       = instr_pc_q;
   assign bus.instr_valid    = instr_valid_q;
   assign bus.fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a PC/expected-fetch model.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned TIMEOUT  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(
      .RESET_PC       (RESET_PC),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.pc_offset      = '0;
      bus.offset_valid   = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      step();
      step();
      rst    = 1'b0;
      exp_pc = RESET_PC;
   endtask

   // Runs one fetch: accept request, wait lat idle cycles, return data; reports what decode sees.
   task automatic fetch(input int lat, input logic [31:0] data, output logic [31:0] addr,
                        output logic [31:0] got_instr, output logic [31:0] got_pc,
                        output bit ok);
      int waited = 0;
      ok        = 1'b0;
      addr      = 32'hxxxx_xxxx;
      got_instr = 32'hxxxx_xxxx;
      got_pc    = 32'hxxxx_xxxx;
      bus.imem_req_ready = 1'b1;
      while (bus.imem_req_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) begin
         bus.imem_req_ready = 1'b0;
         return;
      end
      addr = bus.imem_addr;
      step();
      bus.imem_req_ready = 1'b0;
      repeat (lat) step();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      step();
      bus.imem_rsp_valid = 1'b0;
      got_instr = bus.instr;
      got_pc    = bus.instr_pc;
      ok        = (bus.instr_valid === 1'b1);
   endtask

   // Hands the instruction to decode and supplies the next-PC offset.
   task automatic deliver(input logic [31:0] off, input bit together);
      if (together) begin
         bus.instr_ready  = 1'b1;
         bus.offset_valid = 1'b1;
         bus.pc_offset    = off;
         step();
      end else begin
         bus.instr_ready = 1'b1;
         step();
         bus.instr_ready = 1'b0;
         repeat ($urandom_range(0, 2)) step();
         bus.offset_valid = 1'b1;
         bus.pc_offset    = off;
         step();
      end
      bus.instr_ready  = 1'b0;
      bus.offset_valid = 1'b0;
      bus.pc_offset    = '0;
      exp_pc           = exp_pc + off;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      step();
      n_vec++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0 ||
          bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b iv=%b err=%b instr=%h ipc=%h want 0",
                  bus.imem_req_valid, bus.instr_valid, bus.fetch_err, bus.instr, bus.instr_pc);
      end
      rst    = 1'b0;
      exp_pc = RESET_PC;
      #1;
      n_vec++;
      if (bus.imem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL req_after_release: got %b want 0", bus.imem_req_valid);
      end
      step();
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         n_err++;
         $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h",
                  bus.imem_req_valid, bus.imem_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] addr, got_i, got_pc, data;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         data = $urandom;
         fetch(0, data, addr, got_i, got_pc, ok);
         n_vec++;
         if (!ok || addr !== exp_pc || got_pc !== exp_pc || got_i !== data) begin
            n_err++;
            $display("FAIL seq_fetch%0d: got ok=%b addr=%h ipc=%h instr=%h want addr=ipc=%h instr=%h",
                     i, ok, addr, got_pc, got_i, exp_pc, data);
         end
         deliver(32'd4, i[0]);
      end
   endtask

   task automatic test_branch();
      logic [31:0] addr, got_i, got_pc;
      logic [31:0] targets [3];
      logic [31:0] offs [3];
      bit ok;
      targets = '{32'h100, 32'hF8, 32'h108};
      offs    = '{32'hFFFF_FFF8, 32'h10, 32'h4};
      fetch(1, 32'h1234_5678, addr, got_i, got_pc, ok);
      deliver(32'h100 - exp_pc, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fetch(0, ~targets[i], addr, got_i, got_pc, ok);
         n_vec++;
         if (!ok || addr !== targets[i] || got_pc !== targets[i] || got_i !== ~targets[i]) begin
            n_err++;
            $display("FAIL branch%0d: got ok=%b addr=%h ipc=%h want %h",
                     i, ok, addr, got_pc, targets[i]);
         end
         deliver(offs[i], i[0]);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] addr, got_i, got_pc;
      bit ok;
      fetch(0, 32'hA5A5_0000, addr, got_i, got_pc, ok);
      deliver(32'hFFFF_FFFC - exp_pc, 1'b1);
      fetch(2, 32'hA5A5_0001, addr, got_i, got_pc, ok);
      n_vec++;
      if (!ok || addr !== 32'hFFFF_FFFC || got_pc !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_top: got ok=%b addr=%h ipc=%h want FFFFFFFC", ok, addr, got_pc);
      end
      deliver(32'd4, 1'b0);
      fetch(0, 32'hA5A5_0002, addr, got_i, got_pc, ok);
      n_vec++;
      if (!ok || addr !== 32'h0 || got_pc !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_zero: got ok=%b addr=%h ipc=%h want 00000000", ok, addr, got_pc);
      end
      deliver(32'd0, 1'b1);
   endtask

   task automatic test_random();
      logic [31:0] addr, got_i, got_pc, data, off, r;
      bit ok;
      for (int i = 0; i < 24; i++) begin
         data = $urandom;
         fetch($urandom_range(0, 4), data, addr, got_i, got_pc, ok);
         n_vec++;
         if (!ok || addr !== exp_pc || got_pc !== exp_pc || got_i !== data) begin
            n_err++;
            $display("FAIL rand%0d: got ok=%b addr=%h ipc=%h instr=%h want addr=ipc=%h instr=%h",
                     i, ok, addr, got_pc, got_i, exp_pc, data);
         end
         r = $urandom;
         case ($urandom_range(0, 3))
            0:       off = 32'd4;
            1:       off = 32'd0;
            2:       off = {r[31:2], 2'b00};
            default: off = 32'hFFFF_FFFC - exp_pc;
         endcase
         deliver(off, r[0]);
      end
   endtask

   task automatic test_stall();
      logic [31:0] addr, got_i, got_pc, data;
      bit ok;
      int bad = 0;
      data = $urandom;
      fetch(1, data, addr, got_i, got_pc, ok);
      for (int i = 0; i < 5; i++) begin
         bus.instr_ready  = 1'b0;
         bus.offset_valid = 1'b1;
         bus.pc_offset    = 32'h40;
         step();
         if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.instr_pc !== exp_pc ||
             bus.imem_req_valid !== 1'b0) begin
            bad++;
         end
      end
      bus.offset_valid = 1'b0;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL stall_hold: got %0d unstable cycles (iv=%b instr=%h ipc=%h req=%b) want 0",
                  bad, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req_valid);
      end
      deliver(32'd4, 1'b1);
      fetch(0, 32'h0BAD_F00D, addr, got_i, got_pc, ok);
      n_vec++;
      if (!ok || addr !== exp_pc) begin
         n_err++;
         $display("FAIL stall_next_addr: got ok=%b addr=%h want %h", ok, addr, exp_pc);
      end
      deliver(32'd4, 1'b0);
   endtask

   task automatic test_limit_rsp();
      logic [31:0] addr, got_i, got_pc;
      bit ok;
      fetch(TIMEOUT - 1, 32'h5EED_0001, addr, got_i, got_pc, ok);
      n_vec++;
      if (!ok || bus.fetch_err !== 1'b0 || got_i !== 32'h5EED_0001 || got_pc !== exp_pc) begin
         n_err++;
         $display("FAIL rsp_on_limit: got ok=%b err=%b instr=%h ipc=%h want ok=1 err=0 %h/%h",
                  ok, bus.fetch_err, got_i, got_pc, 32'h5EED_0001, exp_pc);
      end
      deliver(32'd4, 1'b1);
   endtask

   task automatic test_misaligned();
      logic [31:0] addr, got_i, got_pc, held_pc;
      bit ok;
      int bad = 0;
      fetch(0, 32'h1111_2222, addr, got_i, got_pc, ok);
      held_pc          = exp_pc;
      bus.instr_ready  = 1'b1;
      bus.offset_valid = 1'b1;
      bus.pc_offset    = 32'h6;
      step();
      drive_idle();
      n_vec++;
      if (bus.fetch_err !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.imem_addr !== held_pc) begin
         n_err++;
         $display("FAIL misaligned: got err=%b req=%b addr=%h want err=1 req=0 addr=%h",
                  bus.fetch_err, bus.imem_req_valid, bus.imem_addr, held_pc);
      end
      for (int i = 0; i < 8; i++) begin
         bus.offset_valid   = $urandom_range(0, 1);
         bus.pc_offset      = 32'd4;
         bus.imem_req_ready = 1'b1;
         bus.imem_rsp_valid = $urandom_range(0, 1);
         bus.instr_ready    = 1'b1;
         step();
         if (bus.fetch_err !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 ||
             bus.imem_addr !== held_pc) begin
            bad++;
         end
      end
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL err_sticky: got %0d bad cycles want 0", bad);
      end
      do_reset();
   endtask

   task automatic test_timeout();
      int waited = 0;
      bit seen_early = 1'b0;
      bus.imem_req_ready = 1'b1;
      while (bus.imem_req_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      step();
      bus.imem_req_ready = 1'b0;
      for (int k = 1; k <= int'(TIMEOUT) + 2; k++) begin
         step();
         if (k < int'(TIMEOUT) && bus.fetch_err !== 1'b0) seen_early = 1'b1;
         if (k == int'(TIMEOUT)) begin
            n_vec++;
            if (bus.fetch_err !== 1'b1) begin
               n_err++;
               $display("FAIL timeout_edge: got err=%b after %0d wait cycles want 1",
                        bus.fetch_err, k);
            end
         end
      end
      n_vec++;
      if (seen_early) begin
         n_err++;
         $display("FAIL timeout_early: got err before %0d cycles want none", TIMEOUT);
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_0000;
      step();
      bus.imem_rsp_valid = 1'b0;
      n_vec++;
      if (bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b1) begin
         n_err++;
         $display("FAIL late_rsp_in_err: got iv=%b err=%b want iv=0 err=1",
                  bus.instr_valid, bus.fetch_err);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [31:0] addr, got_i, got_pc;
      bit ok;
      int bad = 0;
      // Abandon an outstanding fetch and feed it a stale response.
      bus.imem_req_ready = 1'b1;
      for (int i = 0; i < 20 && bus.imem_req_valid !== 1'b1; i++) step();
      step();
      bus.imem_req_ready = 1'b0;
      step();
      #2 rst = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      rst    = 1'b0;
      exp_pc = RESET_PC;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.instr_valid !== 1'b0) bad++;
      end
      bus.imem_rsp_valid = 1'b0;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL stale_rsp: got instr_valid high %0d cycles want 0", bad);
      end
      fetch(0, 32'h600D_0001, addr, got_i, got_pc, ok);
      n_vec++;
      if (!ok || addr !== RESET_PC || got_i !== 32'h600D_0001) begin
         n_err++;
         $display("FAIL refetch_after_rst: got ok=%b addr=%h instr=%h want addr=%h instr=600d0001",
                  ok, addr, got_i, RESET_PC);
      end
      // Reset while decode holds an instruction: instr_valid must drop before the next edge.
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.instr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_drop: got instr_valid=%b want 0", bus.instr_valid);
      end
      do_reset();
   endtask

   initial begin
      drive_idle();
      exp_pc = RESET_PC;
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_random();
      test_stall();
      test_limit_rsp();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion by %0t want finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
